// File: rtl/barrel_shift_arbiter_if.sv
// Request/result bundle for barrel_shift_arbiter: two shift requesters, one result port
// and grant statistics. The arbiter connects through the slave modport.
interface barrel_shift_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic [2:0] req0_amt;
    logic       req0_ctrl;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic [2:0] req1_amt;
    logic       req1_ctrl;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_id;
    logic       out_ready;
    logic [7:0] gnt_cnt0;
    logic [7:0] gnt_cnt1;

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_ctrl,
        input  req1_valid, req1_data, req1_amt, req1_ctrl,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id,
        output gnt_cnt0, gnt_cnt1
    );

    modport master (
        output req0_valid, req0_data, req0_amt, req0_ctrl,
        output req1_valid, req1_data, req1_amt, req1_ctrl,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id,
        input  gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin arbiter sharing one 8-bit logical barrel shifter, with a
// single result register. Define BSA_GRANT_STATS_EN to add saturating per-requester grant counters.
module barrel_shift_arbiter (
    input  logic                  clk,
    input  logic                  rst_n,
    barrel_shift_arbiter_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t     state;
    logic       last_gnt;
    logic [7:0] res_data;
    logic       res_id;

    logic       can_accept;
    logic       gnt0;
    logic       gnt1;
    logic       xfer;
    logic [7:0] op_data;
    logic [2:0] op_amt;
    logic       op_left;
    logic [7:0] stage1;
    logic [7:0] stage2;
    logic [7:0] shifted;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        can_accept = (state == EMPTY) || bus.out_ready;
        gnt0 = rst_n && can_accept && bus.req0_valid && (!bus.req1_valid || last_gnt);
        gnt1 = rst_n && can_accept && bus.req1_valid && (!bus.req0_valid || !last_gnt);
        xfer = gnt0 || gnt1;
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    always_comb begin
        op_data = gnt1 ? bus.req1_data : bus.req0_data;
        op_amt  = gnt1 ? bus.req1_amt  : bus.req0_amt;
        op_left = gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
    end

    // Logarithmic shifter: stages of 1, 2 and 4 bit positions, zero fill.
    always_comb begin
        if (op_amt[0])
            stage1 = op_left ? {op_data[6:0], 1'b0} : {1'b0, op_data[7:1]};
        else
            stage1 = op_data;
        if (op_amt[1])
            stage2 = op_left ? {stage1[5:0], 2'b00} : {2'b00, stage1[7:2]};
        else
            stage2 = stage1;
        if (op_amt[2])
            shifted = op_left ? {stage2[3:0], 4'b0000} : {4'b0000, stage2[7:4]};
        else
            shifted = stage2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            res_data <= '0;
            res_id   <= 1'b0;
            last_gnt <= 1'b1;
        end else if (xfer) begin
            state    <= FULL;
            res_data <= shifted;
            res_id   <= gnt1;
            last_gnt <= gnt1;
        end else if (state == FULL && bus.out_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = res_data;
    assign bus.out_id    = res_id;

`ifdef BSA_GRANT_STATS_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt0 && cnt0 != '1)
                cnt0 <= cnt0 + 8'd1;
            if (gnt1 && cnt1 != '1)
                cnt1 <= cnt1 + 8'd1;
        end
    end

    assign bus.gnt_cnt0 = cnt0;
    assign bus.gnt_cnt1 = cnt1;
`else
    assign bus.gnt_cnt0 = '0;
    assign bus.gnt_cnt1 = '0;
`endif
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Bench for barrel_shift_arbiter: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_barrel_shift_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    barrel_shift_arbiter_if bus();
    barrel_shift_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef BSA_GRANT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: one result slot, last winner, grant tallies.
    int m_valid = 0;
    int m_data  = 0;
    int m_id    = 0;
    int m_last  = 1;
    int m_cnt0  = 0;
    int m_cnt1  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int shift_of(input int d, input int amt, input int left);
        if (left != 0)
            return (d * (1 << amt)) % 256;
        return d / (1 << amt);
    endfunction

    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (m_valid != 0 && !bus.out_ready) return -1;
        if (bus.req0_valid && bus.req1_valid) return 1 - m_last;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = exp_grant();
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_id = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
        end else if (g == 0) begin
            m_valid = 1; m_id = 0; m_last = 0;
            m_data = shift_of(int'(bus.req0_data), int'(bus.req0_amt), int'(bus.req0_ctrl));
            if (m_cnt0 < 255) m_cnt0++;
        end else if (g == 1) begin
            m_valid = 1; m_id = 1; m_last = 1;
            m_data = shift_of(int'(bus.req1_data), int'(bus.req1_amt), int'(bus.req1_ctrl));
            if (m_cnt1 < 255) m_cnt1++;
        end else if (m_valid != 0 && bus.out_ready) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        int g;
        if (chk_en) begin
            g = exp_grant();
            chk("mdl_ready0", 32'(bus.req0_ready), 32'(g == 0));
            chk("mdl_ready1", 32'(bus.req1_ready), 32'(g == 1));
            chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid != 0) begin
                chk("mdl_out_data", 32'(bus.out_data), 32'(m_data));
                chk("mdl_out_id", 32'(bus.out_id), 32'(m_id));
            end
            chk("mdl_cnt0", 32'(bus.gnt_cnt0), STATS ? 32'(m_cnt0) : 32'd0);
            chk("mdl_cnt1", 32'(bus.gnt_cnt1), STATS ? 32'(m_cnt1) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] d,
                           input logic [2:0] a, input bit c);
        if (i == 0) begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a; bus.req0_ctrl = c;
        end else begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a; bus.req1_ctrl = c;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
        set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;

        // Reset state, with requesters valid to show readys are held low.
        tick();
        chk_en = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_id", 32'(bus.out_id), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // req0 alone, left shift by 3.
        set_req(0, 1'b1, 8'b1011_0011, 3'd3, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("r0_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("r0_valid", 32'(bus.out_valid), 32'd1);
        chk("r0_data", 32'(bus.out_data), 32'b1001_1000);
        chk("r0_id", 32'(bus.out_id), 32'd0);
        chk("model_left3", 32'(m_data), 32'b1001_1000);
        tick();
        @(negedge clk);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // req1 alone, right shift by 3 then amt 0, back to back.
        set_req(1, 1'b1, 8'b1011_0011, 3'd3, 1'b0);
        tick();
        bus.req1_amt = 3'd0;
        @(negedge clk);
        chk("r1_data", 32'(bus.out_data), 32'b0001_0110);
        chk("r1_id", 32'(bus.out_id), 32'd1);
        chk("model_right3", 32'(m_data), 32'b0001_0110);
        tick();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("r1_amt0_data", 32'(bus.out_data), 32'b1011_0011);
        tick();

        // Sweep all amounts and directions from requester 0; out_ready toggles, including while empty.
        for (int k = 0; k < 16; k++) begin
            set_req(0, 1'b1, 8'h5A + 8'(k), 3'(k % 8), 1'(k / 8));
            bus.out_ready = 1'(k % 3 != 2);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        bus.out_ready = 1'b0;
        tick();

        // Contention straight out of reset: strict alternation starting at 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(0, 1'b1, 8'h01, 3'd1, 1'b1);
        set_req(1, 1'b1, 8'h80, 3'd1, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alt_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
            chk("alt_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
            if (i > 0) begin
                chk("alt_valid", 32'(bus.out_valid), 32'd1);
                chk("alt_id", 32'(bus.out_id), 32'((i - 1) % 2));
            end
            tick();
        end

        // Backpressure: held result from requester 1 (0x80 >> 1).
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data", 32'(bus.out_data), 32'h40);
            chk("bp_id", 32'(bus.out_id), 32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rel_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("rel_id", 32'(bus.out_id), 32'd0);
        chk("rel_data", 32'(bus.out_data), 32'h02);

        // Reset while full with both requesters pending.
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_cnt0", 32'(bus.gnt_cnt0), 32'd0);
        chk("midrst_cnt1", 32'(bus.gnt_cnt1), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_ready0", 32'(bus.req0_ready), 32'd1);
        chk("postrst_ready1", 32'(bus.req1_ready), 32'd0);
        tick();

        // Counter saturation: 300 transfers from requester 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req1_valid = 1'b0;
        set_req(0, 1'b1, 8'h33, 3'd2, 1'b0);
        repeat (300) tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("sat_cnt0", 32'(bus.gnt_cnt0), STATS ? 32'd255 : 32'd0);
        chk("sat_cnt1", 32'(bus.gnt_cnt1), 32'd0);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
